net_l2req_arb: RTL and testbench

Per-directory request merge stage that feeds the L2-to-directory network. It collects `I_l2todr_req_type` requests from NPORTS L2 pipes (L2I, L2D_0, L2D_1, ... of one core), buffers each in a 2-entry FIFO, and arbitrates round-robin. The winner goes into one registered output channel toward a directory port, tagged with its source index so that snack responses can be routed back.

---
 rtl/net_l2req_arb_pkg.sv | 12 +
 rtl/net_l2req_arb.sv | 147 ++++++++++++++
 tb/tb_net_l2req_arb.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/net_l2req_arb_pkg.sv
// Request payload carried from the L2 pipes toward a directory port.
// The arbiter never looks inside it; only its width matters there.
package net_l2req_arb_pkg;

    typedef struct packed {
        logic [4:0]  nid;
        logic [5:0]  l2id;
        logic [2:0]  cmd;
        logic [49:0] paddr;
    } I_l2todr_req_type;

endpackage

// File: rtl/net_l2req_arb.sv
// Round-robin merge of NPORTS L2 request pipes into one registered directory channel.
// Optional stall counter output is enabled by defining NET_L2REQ_ARB_STATS_EN.
module net_l2req_arb
    import net_l2req_arb_pkg::*;
#(
    parameter int NPORTS = 3,
    localparam int SRCW  = (NPORTS > 1) ? $clog2(NPORTS) : 1,
    localparam int REQ_W = $bits(I_l2todr_req_type)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NPORTS-1:0]              in_req_valid,
    output logic [NPORTS-1:0]              in_req_retry,
    input  logic [NPORTS-1:0][REQ_W-1:0]   in_req,
    output logic                           out_req_valid,
    input  logic                           out_req_retry,
    output logic [REQ_W-1:0]               out_req,
    output logic [SRCW-1:0]                out_req_src
`ifdef NET_L2REQ_ARB_STATS_EN
    ,
    output logic [15:0]                    stall_cnt
`endif
);

    logic [NPORTS-1:0]            push;
    logic [NPORTS-1:0]            pop;
    logic [NPORTS-1:0]            nonempty;
    logic [NPORTS-1:0][REQ_W-1:0] head;

    logic                         out_valid_q, out_valid_d;
    logic [REQ_W-1:0]             out_req_q, out_req_d;
    logic [SRCW-1:0]              out_src_q, out_src_d;
    logic [SRCW-1:0]              rr_ptr_q, rr_ptr_d;

    logic                         out_free;
    logic                         any_grant;
    logic [SRCW-1:0]              grant_idx;
    logic [SRCW:0]                cand;

    for (genvar i = 0; i < NPORTS; i++) begin : g_fifo
        logic [REQ_W-1:0] mem_q [2];
        logic             wr_ptr_q;
        logic             rd_ptr_q;
        logic [1:0]       cnt_q;

        // Retry comes only from the registered count, so it never depends on valid.
        assign in_req_retry[i] = (cnt_q == 2'd2);
        assign push[i]         = in_req_valid[i] & ~in_req_retry[i];
        assign nonempty[i]     = (cnt_q != 2'd0);
        assign head[i]         = mem_q[rd_ptr_q];

        always_ff @(posedge clk) begin
            if (push[i]) begin
                mem_q[wr_ptr_q] <= in_req[i];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                cnt_q    <= 2'd0;
            end else begin
                if (push[i]) begin
                    wr_ptr_q <= ~wr_ptr_q;
                end
                if (pop[i]) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                case ({push[i], pop[i]})
                    2'b10:   cnt_q <= cnt_q + 2'd1;
                    2'b01:   cnt_q <= cnt_q - 2'd1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    // First non-empty source at or after rr_ptr, wrapping modulo NPORTS.
    always_comb begin
        any_grant = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NPORTS; k++) begin
            cand = {1'b0, rr_ptr_q} + (SRCW+1)'(k);
            if (cand >= (SRCW+1)'(NPORTS)) begin
                cand = cand - (SRCW+1)'(NPORTS);
            end
            if (!any_grant && nonempty[cand[SRCW-1:0]]) begin
                any_grant = 1'b1;
                grant_idx = cand[SRCW-1:0];
            end
        end
    end

    always_comb begin
        out_free    = ~out_valid_q | ~out_req_retry;
        pop         = '0;
        out_valid_d = out_valid_q;
        out_req_d   = out_req_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (out_free) begin
            out_valid_d = any_grant;
            if (any_grant) begin
                pop[grant_idx] = 1'b1;
                out_req_d      = head[grant_idx];
                out_src_d      = grant_idx;
                rr_ptr_d       = (grant_idx == SRCW'(NPORTS-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_req_q   <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_req_q   <= out_req_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_req_valid = out_valid_q;
    assign out_req       = out_req_q;
    assign out_req_src   = out_src_q;

`ifdef NET_L2REQ_ARB_STATS_EN
    logic [15:0] stall_cnt_q;

    // Saturating: a long stall must not alias to a short one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 16'd0;
        end else if (out_valid_q && out_req_retry && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_net_l2req_arb.sv
// Directed bench for net_l2req_arb: scoreboard of expected {src,payload} in grant order.
module tb_net_l2req_arb;
    import net_l2req_arb_pkg::*;

    localparam int NPORTS = 3;
    localparam int SRCW   = 2;
    localparam int REQ_W  = $bits(I_l2todr_req_type);

    typedef struct packed {
        logic [SRCW-1:0]  src;
        logic [REQ_W-1:0] d;
    } exp_t;

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic [NPORTS-1:0]            in_req_valid = '0;
    logic [NPORTS-1:0]            in_req_retry;
    logic [NPORTS-1:0][REQ_W-1:0] in_req = '0;
    logic                         out_req_valid;
    logic                         out_req_retry = 1'b0;
    logic [REQ_W-1:0]             out_req;
    logic [SRCW-1:0]              out_req_src;
`ifdef NET_L2REQ_ARB_STATS_EN
    logic [15:0]                  stall_cnt;
`endif

    int errors = 0;
    int checks = 0;
    exp_t sb[$];
    logic [REQ_W-1:0] sq[NPORTS][$];

    always #5 clk = ~clk;

    net_l2req_arb #(.NPORTS(NPORTS)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_req_valid  (in_req_valid),
        .in_req_retry  (in_req_retry),
        .in_req        (in_req),
        .out_req_valid (out_req_valid),
        .out_req_retry (out_req_retry),
        .out_req       (out_req),
        .out_req_src   (out_req_src)
`ifdef NET_L2REQ_ARB_STATS_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output transfers happen at the next rising edge; compare against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (reset && out_req_valid && !out_req_retry) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out: got src=%0d data=%0h expected no output", out_req_src, out_req);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_order", 80'({out_req_src, out_req}), 80'(e));
            end
        end
    end

    // Present each source's queue head until accepted; returns aligned just after a rising edge.
    task automatic run_streams(input bit no_retry);
        logic [NPORTS-1:0] acc;
        bit busy;
        int cyc;
        cyc = 0;
        while (1) begin
            busy = 1'b0;
            for (int i = 0; i < NPORTS; i++) begin
                if (sq[i].size() > 0) begin
                    in_req_valid[i] = 1'b1;
                    in_req[i]       = sq[i][0];
                    busy            = 1'b1;
                end else begin
                    in_req_valid[i] = 1'b0;
                end
            end
            if (!busy) break;
            if (cyc >= 200) begin
                checks++;
                errors++;
                $error("FAIL stream_timeout: got pending inputs expected all accepted");
                for (int i = 0; i < NPORTS; i++) sq[i].delete();
                in_req_valid = '0;
                break;
            end
            @(negedge clk);
            if (no_retry) chk("no_retry", 80'(in_req_retry), 80'(0));
            for (int i = 0; i < NPORTS; i++) acc[i] = in_req_valid[i] & ~in_req_retry[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < NPORTS; i++) if (acc[i]) void'(sq[i].pop_front());
            cyc++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 80'(sb.size()), 80'(0));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb.delete();
        tick(2);
        reset = 1'b1;
    endtask

    initial begin
        logic [REQ_W-1:0] a, v;
        logic [REQ_W-1:0] b[3];
        logic [REQ_W-1:0] c[3];
        int w;

        // Reset state
        #3 reset = 1'b0;
        tick(2);
        @(negedge clk);
        chk("rst_valid", 80'(out_req_valid), 80'(0));
        chk("rst_req", 80'(out_req), 80'(0));
        chk("rst_src", 80'(out_req_src), 80'(0));
        chk("rst_retry", 80'(in_req_retry), 80'(0));
`ifdef NET_L2REQ_ARB_STATS_EN
        chk("rst_stall", 80'(stall_cnt), 80'(0));
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single source, 1-cycle latency, valid for exactly one cycle
        a = rnd();
        sb.push_back({2'd1, a});
        sq[1].push_back(a);
        run_streams(1'b0);
        @(negedge clk);
        chk("lat_not_yet", 80'(out_req_valid), 80'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("single_valid", 80'(out_req_valid), 80'(1));
        chk("single_data", 80'(out_req), 80'(a));
        chk("single_src", 80'(out_req_src), 80'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("single_one_cycle", 80'(out_req_valid), 80'(0));
        @(posedge clk);
        #1;
        drain();

        // Fairness from rr_ptr=0: grants rotate 0,1,2
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < NPORTS; s++) begin
                v = rnd();
                sq[s].push_back(v);
                sb.push_back({SRCW'(s), v});
            end
        end
        run_streams(1'b0);
        drain();

        // Back-pressure: B0 held on the output, B1/B2 fill source 0
        out_req_retry = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b[i] = rnd();
            sq[0].push_back(b[i]);
            sb.push_back({2'd0, b[i]});
        end
        run_streams(1'b0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("hold_valid", 80'(out_req_valid), 80'(1));
            chk("hold_data", 80'(out_req), 80'(b[0]));
            chk("hold_full_retry", 80'(in_req_retry[0]), 80'(1));
            @(posedge clk);
            #1;
        end
        out_req_retry = 1'b0;
        @(negedge clk);
        chk("retry_reg_on_pop", 80'(in_req_retry[0]), 80'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("retry_release", 80'(in_req_retry[0]), 80'(0));
        @(posedge clk);
        #1;
        drain();

        // Sole requester at one per cycle: push and pop together, retry never set
        for (int i = 0; i < 3; i++) begin
            c[i] = rnd();
            sq[2].push_back(c[i]);
            sb.push_back({2'd2, c[i]});
        end
        run_streams(1'b1);
        @(negedge clk);
        chk("pushpop_stream_valid", 80'(out_req_valid), 80'(1));
        @(posedge clk);
        #1;
        drain();

        // Async reset with requests buffered, then rr_ptr restarts at 0
        out_req_retry = 1'b1;
        for (int i = 0; i < 3; i++) sq[0].push_back(rnd());
        for (int i = 0; i < 2; i++) sq[1].push_back(rnd());
        run_streams(1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", 80'(out_req_valid), 80'(0));
        chk("async_rst_req", 80'(out_req), 80'(0));
        chk("async_rst_retry", 80'(in_req_retry), 80'(0));
        sb.delete();
        out_req_retry = 1'b0;
        tick(2);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_idle", 80'(out_req_valid), 80'(0));
            @(posedge clk);
            #1;
        end
        a = rnd();
        v = rnd();
        sq[0].push_back(a);
        sq[2].push_back(v);
        sb.push_back({2'd0, a});
        sb.push_back({2'd2, v});
        run_streams(1'b0);
        drain();

`ifdef NET_L2REQ_ARB_STATS_EN
        // Stall counter: exact count, then saturation
        do_reset();
        out_req_retry = 1'b1;
        a = rnd();
        sq[1].push_back(a);
        sb.push_back({2'd1, a});
        run_streams(1'b0);
        w = 0;
        @(negedge clk);
        while (!out_req_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("stat_valid", 80'(out_req_valid), 80'(1));
        chk("stat_zero", 80'(stall_cnt), 80'(0));
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stat_five", 80'(stall_cnt), 80'(5));
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("stat_sat", 80'(stall_cnt), 80'(16'hFFFF));
        @(posedge clk);
        @(negedge clk);
        chk("stat_no_wrap", 80'(stall_cnt), 80'(16'hFFFF));
        @(posedge clk);
        #1;
        out_req_retry = 1'b0;
        drain();
`else
        w = 0;
`endif

        chk("final_sb_empty", 80'(sb.size()), 80'(w * 0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
